data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Round-robin arbiter that shares the single-write, dual-read `data_mem` block (6 entries × 256 bits) between two requesters, such as the load/store unit and the ALU writeback stage. It accepts one memory access per cycle and drives `data_mem`'s pointer, data and enable pins. It returns read data with a per-requester valid strobe, rejects out-of-range pointers, and keeps saturating per-requester grant counters for performance debug.

## Interface
- `DEPTH`, 6, number of valid memory entries; legal pointers are 0..DEPTH-1.
- `DW`, 256, data width.
- `AW`, 3, pointer width.
- `CW`, 16, grant counter width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req[1:0]`  in  2  access request per requester; held with its fields until `gnt`.
- `we[1:0]`  in  2  1 = write, 0 = read (dual read).
- `wptr0`/`wptr1`  in  AW  write pointer.
- `wdata0`/`wdata1`  in  DW  write data.
- `rptr1_0`/`rptr1_1`, `rptr2_0`/`rptr2_1`  in  AW  read pointers for ports 1 and 2.
- `gnt[1:0]`  out  2  one-cycle pulse: request accepted this cycle.
- `err[1:0]`  out  2  one-cycle pulse: request rejected (pointer ≥ DEPTH).
- `rvalid[1:0]`  out  2  read data on `rdata1`/`rdata2` belongs to this requester.
- `rdata1`, `rdata2`  out  DW  pass-through of `data_mem` `data1`/`data2`.
- `gcnt0`, `gcnt1`  out  CW  saturating granted-access counters.
- `mem_pointer1`, `mem_pointer2`, `mem_write_data_pointer`  out  AW  to `data_mem`.
- `mem_data_to_write`  out  DW  to `data_mem`.
- `mem_write_data`, `mem_read_data`  out  1  `data_mem` enables.
- `mem_data1`, `mem_data2`  in  DW  from `data_mem`.

## Operation
- Arbitration is combinational within the cycle. With one requester active, it wins. With both active, the requester not equal to `last` wins.
- `last` is a 1-bit register holding the most recent winner, including rejected winners. Reset value 0, so requester 1 wins the first tie.
- Validity check on the winner:
  - Write: `wptr` < DEPTH.
  - Read: both `rptr1` and `rptr2` < DEPTH.
  - Invalid: assert `err[w]`, do not assert `gnt[w]`, keep both mem enables low. The request is consumed, so the requester must drop or change it.
- Valid write: `mem_write_data`=1, `mem_write_data_pointer`=wptr, `mem_data_to_write`=wdata, `gnt[w]`=1.
- Valid read: `mem_read_data`=1, `mem_pointer1`/`mem_pointer2`=rptr1/rptr2, `gnt[w]`=1. Set `rd_owner`=w and `rd_pend`=1 for the next cycle.
- `rvalid[rd_owner]` = `rd_pend`, registered. Data on `rdata1`/`rdata2` is valid only while `rvalid` is high.
- The loser sees no `gnt` and retries automatically because it holds `req`. No requester waits more than one cycle behind the other.
- `gcntN` increments on `gnt[N]` and saturates at 2^CW−1. Errors are not counted.
- Idle cycle (no `req`): all mem enables 0 and pointer/data outputs 0. `last` and `rd_pend` update normally; `rd_pend` becomes 0.

## Timing
- Grant latency: 0 cycles (same cycle as `req` when the requester wins).
- Write commits at the rising edge ending the grant cycle.
- Read latency: `rvalid` and data one cycle after `gnt`.
- Back-to-back: one access per cycle sustained. A read is followed directly by a read or a write from either requester.
- Read in cycle N+1 of an entry written in cycle N returns the new data, because `data_mem` commits the write first.
- Reset state: `last`=0, `rd_pend`=0, `gcnt*`=0.
- All outputs 0 while `reset` is high, including mem enables. `req` is ignored during reset.
- Reset asserted the cycle after a read grant: `rvalid` stays 0 and the pending read is dropped.

## Structure
- Shared package `data_mem_pkg`:
  - `DEPTH`, `DW`, `AW` constants.
  - Requester-ID typedef.
  - Access-type enum `ACC_READ` / `ACC_WRITE`.
- One natural sub-module, `rr_pick2`: a 2-way round-robin picker (inputs `req[1:0]`, `last`; output winner, `any`).
- The counters and read-return pipeline stay inline.

## Test plan
- Reset, then write from requester 0 only (`wptr0`=2, `wdata0`=0x55…55) → `gnt[0]` same cycle, `mem_write_data`=1. Read of entry 2 one cycle later → `rvalid[0]` next cycle, `rdata1`=0x55…55.
- Both requesters read every cycle for 6 cycles → grants alternate 1,0,1,0,1,0 and `rvalid` follows one cycle later. `gcnt0`=`gcnt1`=3.
- Requester 1 writes 0xAA…AA to entry 5 in cycle N; requester 0 reads entry 5 on both ports in cycle N+1 → both `rdata1` and `rdata2` = 0xAA…AA with `rvalid[0]`.
- Requester 0 write with `wptr0`=6, then read with `rptr2_0`=7 → `err[0]` pulses, no `gnt`, mem enables 0, `gcnt0` unchanged.
- Force `gcnt1` near saturation (CW override = 4) with 20 grants → `gcnt1` holds at 15.
- Read granted in cycle N, `reset` high in N+1 → `rvalid`=0, all counters 0, `last`=0 after reset; the next tie is granted to requester 1.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared constants and types for the data_mem block and its arbiter.
package data_mem_pkg;

    localparam int DEPTH = 6;
    localparam int DW    = 256;
    localparam int AW    = 3;
    localparam int CW    = 16;

    // Requester index: 0 or 1
    typedef logic req_id_t;

    typedef enum logic {
        ACC_READ  = 1'b0,
        ACC_WRITE = 1'b1
    } acc_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: on a tie, the requester that did not win last time goes.
module rr_pick2
    import data_mem_pkg::*;
(
    input  logic [1:0] i_req,
    input  req_id_t    i_last,
    output req_id_t    o_winner,
    output logic       o_any
);

    always_comb begin
        o_any = |i_req;
        if (&i_req) begin
            o_winner = ~i_last;
        end else begin
            o_winner = i_req[1];
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-write / dual-read data_mem between two requesters, one access per cycle,
// with pointer range checking, read-return strobes and saturating grant counters.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int DEPTH = data_mem_pkg::DEPTH,
    parameter int DW    = data_mem_pkg::DW,
    parameter int AW    = data_mem_pkg::AW,
    parameter int CW    = data_mem_pkg::CW
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [1:0]    i_req,
    input  logic [1:0]    i_we,
    input  logic [AW-1:0] i_wptr0,
    input  logic [AW-1:0] i_wptr1,
    input  logic [DW-1:0] i_wdata0,
    input  logic [DW-1:0] i_wdata1,
    input  logic [AW-1:0] i_rptr1_0,
    input  logic [AW-1:0] i_rptr1_1,
    input  logic [AW-1:0] i_rptr2_0,
    input  logic [AW-1:0] i_rptr2_1,
    output logic [1:0]    o_gnt,
    output logic [1:0]    o_err,
    output logic [1:0]    o_rvalid,
    output logic [DW-1:0] o_rdata1,
    output logic [DW-1:0] o_rdata2,
    output logic [CW-1:0] o_gcnt0,
    output logic [CW-1:0] o_gcnt1,
    output logic [AW-1:0] o_mem_pointer1,
    output logic [AW-1:0] o_mem_pointer2,
    output logic [AW-1:0] o_mem_write_data_pointer,
    output logic [DW-1:0] o_mem_data_to_write,
    output logic          o_mem_write_data,
    output logic          o_mem_read_data,
    input  logic [DW-1:0] i_mem_data1,
    input  logic [DW-1:0] i_mem_data2
);

    req_id_t       r_last;
    logic          r_rd_pend;
    req_id_t       r_rd_owner;
    logic [CW-1:0] r_gcnt0;
    logic [CW-1:0] r_gcnt1;

    req_id_t       w_win;
    logic          w_any;
    acc_t          w_acc;
    logic [AW-1:0] w_wptr;
    logic [DW-1:0] w_wdata;
    logic [AW-1:0] w_rptr1;
    logic [AW-1:0] w_rptr2;
    logic          w_ok;
    logic          w_go;
    logic          w_grant;
    logic          w_reject;
    logic          w_rd_grant;

    rr_pick2 u_pick (
        .i_req    (i_req),
        .i_last   (r_last),
        .o_winner (w_win),
        .o_any    (w_any)
    );

    always_comb begin
        w_acc   = i_we[w_win] ? ACC_WRITE : ACC_READ;
        w_wptr  = w_win ? i_wptr1   : i_wptr0;
        w_wdata = w_win ? i_wdata1  : i_wdata0;
        w_rptr1 = w_win ? i_rptr1_1 : i_rptr1_0;
        w_rptr2 = w_win ? i_rptr2_1 : i_rptr2_0;
        if (w_acc == ACC_WRITE) begin
            w_ok = int'(w_wptr) < DEPTH;
        end else begin
            w_ok = (int'(w_rptr1) < DEPTH) && (int'(w_rptr2) < DEPTH);
        end
        // Requests are ignored entirely while reset is held
        w_go       = w_any && !i_reset;
        w_grant    = w_go && w_ok;
        w_reject   = w_go && !w_ok;
        w_rd_grant = w_grant && (w_acc == ACC_READ);
    end

    always_comb begin
        o_gnt                    = 2'b00;
        o_err                    = 2'b00;
        o_mem_write_data         = 1'b0;
        o_mem_read_data          = 1'b0;
        o_mem_write_data_pointer = '0;
        o_mem_data_to_write      = '0;
        o_mem_pointer1           = '0;
        o_mem_pointer2           = '0;
        if (w_grant) begin
            o_gnt[w_win] = 1'b1;
            if (w_acc == ACC_WRITE) begin
                o_mem_write_data         = 1'b1;
                o_mem_write_data_pointer = w_wptr;
                o_mem_data_to_write      = w_wdata;
            end else begin
                o_mem_read_data = 1'b1;
                o_mem_pointer1  = w_rptr1;
                o_mem_pointer2  = w_rptr2;
            end
        end
        if (w_reject) begin
            o_err[w_win] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last     <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_rd_owner <= 1'b0;
            r_gcnt0    <= '0;
            r_gcnt1    <= '0;
        end else begin
            if (w_any) begin
                r_last <= w_win;
            end
            r_rd_pend <= w_rd_grant;
            if (w_rd_grant) begin
                r_rd_owner <= w_win;
            end
            if (o_gnt[0] && (r_gcnt0 != '1)) begin
                r_gcnt0 <= r_gcnt0 + 1'b1;
            end
            if (o_gnt[1] && (r_gcnt1 != '1)) begin
                r_gcnt1 <= r_gcnt1 + 1'b1;
            end
        end
    end

    // Every output is forced low while reset is held, including the read return
    always_comb begin
        o_rvalid = 2'b00;
        if (r_rd_pend && !i_reset) begin
            o_rvalid[r_rd_owner] = 1'b1;
        end
        o_rdata1 = i_reset ? '0 : i_mem_data1;
        o_rdata2 = i_reset ? '0 : i_mem_data2;
        o_gcnt0  = i_reset ? '0 : r_gcnt0;
        o_gcnt1  = i_reset ? '0 : r_gcnt1;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a registered-read data_mem model behind it.
module tb_data_mem_arbiter;

    localparam int DEPTH = 6;
    localparam int DW    = 256;
    localparam int AW    = 3;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] wptr0, wptr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [AW-1:0] rptr1_0, rptr1_1, rptr2_0, rptr2_1;
    logic [1:0]    gnt, err, rvalid;
    logic [DW-1:0] rdata1, rdata2;
    logic [CW-1:0] gcnt0, gcnt1;
    logic [AW-1:0] mem_pointer1, mem_pointer2, mem_write_data_pointer;
    logic [DW-1:0] mem_data_to_write;
    logic          mem_write_data, mem_read_data;
    logic [DW-1:0] mem_data1, mem_data2;

    logic [DW-1:0] mem [8];

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [DW-1:0] PAT55 = {32{8'h55}};
    localparam logic [DW-1:0] PATAA = {32{8'hAA}};

    always #5 clk = ~clk;

    data_mem_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW), .CW(CW)) dut (
        .i_clk                    (clk),
        .i_reset                  (reset),
        .i_req                    (req),
        .i_we                     (we),
        .i_wptr0                  (wptr0),
        .i_wptr1                  (wptr1),
        .i_wdata0                 (wdata0),
        .i_wdata1                 (wdata1),
        .i_rptr1_0                (rptr1_0),
        .i_rptr1_1                (rptr1_1),
        .i_rptr2_0                (rptr2_0),
        .i_rptr2_1                (rptr2_1),
        .o_gnt                    (gnt),
        .o_err                    (err),
        .o_rvalid                 (rvalid),
        .o_rdata1                 (rdata1),
        .o_rdata2                 (rdata2),
        .o_gcnt0                  (gcnt0),
        .o_gcnt1                  (gcnt1),
        .o_mem_pointer1           (mem_pointer1),
        .o_mem_pointer2           (mem_pointer2),
        .o_mem_write_data_pointer (mem_write_data_pointer),
        .o_mem_data_to_write      (mem_data_to_write),
        .o_mem_write_data         (mem_write_data),
        .o_mem_read_data          (mem_read_data),
        .i_mem_data1              (mem_data1),
        .i_mem_data2              (mem_data2)
    );

    // data_mem model: write commits at the edge, read data registered one cycle later
    always @(posedge clk) begin
        if (mem_write_data) mem[mem_write_data_pointer] <= mem_data_to_write;
        if (mem_read_data) begin
            mem_data1 <= mem[mem_pointer1];
            mem_data2 <= mem[mem_pointer2];
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int exp_w;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        mem_data1 = '0;
        mem_data2 = '0;
        reset  = 1'b1;
        req    = 2'b11;
        we     = 2'b11;
        wptr0  = 3'd1;
        wptr1  = 3'd1;
        wdata0 = PAT55;
        wdata1 = PATAA;
        rptr1_0 = '0; rptr1_1 = '0; rptr2_0 = '0; rptr2_1 = '0;

        @(negedge clk);
        chk("rst_gnt", 256'(gnt), 256'(2'b00));
        chk("rst_wen", 256'(mem_write_data), 256'(1'b0));
        chk("rst_ren", 256'(mem_read_data), 256'(1'b0));
        chk("rst_rvalid", 256'(rvalid), 256'(2'b00));
        chk("rst_gcnt0", 256'(gcnt0), 256'(0));
        tick;
        tick;

        // write entry 2 from requester 0, then read it back
        reset = 1'b0;
        req = 2'b01; we = 2'b01; wptr0 = 3'd2; wdata0 = PAT55;
        @(negedge clk);
        chk("wr0_gnt", 256'(gnt), 256'(2'b01));
        chk("wr0_wen", 256'(mem_write_data), 256'(1'b1));
        chk("wr0_wptr", 256'(mem_write_data_pointer), 256'(3'd2));
        chk("wr0_wdata", mem_data_to_write, PAT55);
        tick;
        we = 2'b00; rptr1_0 = 3'd2; rptr2_0 = 3'd2;
        @(negedge clk);
        chk("rd0_gnt", 256'(gnt), 256'(2'b01));
        chk("rd0_ren", 256'(mem_read_data), 256'(1'b1));
        chk("rd0_ptr1", 256'(mem_pointer1), 256'(3'd2));
        tick;
        req = 2'b00;
        @(negedge clk);
        chk("rd0_rvalid", 256'(rvalid), 256'(2'b01));
        chk("rd0_rdata1", rdata1, PAT55);
        chk("idle_ren", 256'(mem_read_data), 256'(1'b0));
        chk("idle_ptr1", 256'(mem_pointer1), 256'(0));
        tick;

        // both read every cycle: last winner was 0, so requester 1 goes first
        req = 2'b11; we = 2'b00;
        rptr1_0 = 3'd0; rptr2_0 = 3'd1; rptr1_1 = 3'd3; rptr2_1 = 3'd4;
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            exp_w = (i % 2 == 0) ? 1 : 0;
            @(negedge clk);
            chk($sformatf("tie_gnt%0d", i), 256'(gnt), 256'(2'b01 << exp_w));
            chk($sformatf("tie_rv%0d", i), 256'(rvalid), (prev < 0) ? 256'(0) : 256'(2'b01 << prev));
            prev = exp_w;
            tick;
        end
        req = 2'b00;
        @(negedge clk);
        chk("tie_rv_last", 256'(rvalid), 256'(2'b01));
        chk("tie_gcnt0", 256'(gcnt0), 256'(5));
        chk("tie_gcnt1", 256'(gcnt1), 256'(3));
        tick;

        // write-then-read of entry 5 returns the new data
        req = 2'b10; we = 2'b10; wptr1 = 3'd5; wdata1 = PATAA;
        @(negedge clk);
        chk("raw_wgnt", 256'(gnt), 256'(2'b10));
        tick;
        req = 2'b01; we = 2'b00; rptr1_0 = 3'd5; rptr2_0 = 3'd5;
        @(negedge clk);
        chk("raw_rgnt", 256'(gnt), 256'(2'b01));
        tick;
        req = 2'b00;
        @(negedge clk);
        chk("raw_rvalid", 256'(rvalid), 256'(2'b01));
        chk("raw_rdata1", rdata1, PATAA);
        chk("raw_rdata2", rdata2, PATAA);
        chk("raw_gcnt1", 256'(gcnt1), 256'(4));
        tick;

        // out-of-range pointers
        req = 2'b01; we = 2'b01; wptr0 = 3'd6;
        @(negedge clk);
        chk("errw_err", 256'(err), 256'(2'b01));
        chk("errw_gnt", 256'(gnt), 256'(2'b00));
        chk("errw_wen", 256'(mem_write_data), 256'(1'b0));
        tick;
        we = 2'b00; rptr1_0 = 3'd0; rptr2_0 = 3'd7;
        @(negedge clk);
        chk("errr_err", 256'(err), 256'(2'b01));
        chk("errr_gnt", 256'(gnt), 256'(2'b00));
        chk("errr_ren", 256'(mem_read_data), 256'(1'b0));
        tick;
        req = 2'b00;
        @(negedge clk);
        chk("err_rvalid", 256'(rvalid), 256'(2'b00));
        chk("err_gcnt0", 256'(gcnt0), 256'(6));
        chk("err_clr", 256'(err), 256'(2'b00));
        tick;

        // saturation of the 4-bit counter: 4 + 20 grants clamps at 15
        req = 2'b10; we = 2'b00; rptr1_1 = 3'd1; rptr2_1 = 3'd2;
        repeat (10) tick;
        @(negedge clk);
        chk("sat_mid", 256'(gcnt1), 256'(14));
        repeat (10) tick;
        req = 2'b00;
        @(negedge clk);
        chk("sat_end", 256'(gcnt1), 256'(15));
        tick;

        // reset right after a read grant drops the return and clears last
        req = 2'b10; we = 2'b00;
        @(negedge clk);
        chk("rr_gnt", 256'(gnt), 256'(2'b10));
        tick;
        reset = 1'b1; req = 2'b00;
        @(negedge clk);
        chk("rr_rvalid_rst", 256'(rvalid), 256'(2'b00));
        chk("rr_gcnt1_rst", 256'(gcnt1), 256'(0));
        tick;
        reset = 1'b0; req = 2'b11; we = 2'b00;
        @(negedge clk);
        chk("rr_tie_gnt", 256'(gnt), 256'(2'b10));
        chk("rr_rvalid_post", 256'(rvalid), 256'(2'b00));
        chk("rr_gcnt0_post", 256'(gcnt0), 256'(0));
        chk("rr_gcnt1_post", 256'(gcnt1), 256'(0));
        tick;
        req = 2'b00;
        @(negedge clk);
        chk("rr_rvalid_ret", 256'(rvalid), 256'(2'b10));
        chk("rr_gcnt1_one", 256'(gcnt1), 256'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
